alarm_trigger: RTL

- Generates the `alarm` trigger consumed by the LED alarm indicator.
- Compares the running time of day against the programmed alarm time, raises `alarm` on a match and holds it until stop, snooze or ring timeout.
- Sits between the time-keeping counter / button debouncers and the LED alarm block.
- Single clock domain; all timing is counted in 1 Hz tick pulses.

---
 rtl/alarm_trigger.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alarm_trigger.sv
// Alarm trigger: raises `alarm` on the rising edge of a time-of-day match and holds it
// until stop, snooze or ring timeout. Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_trigger #(
  parameter int RING_S   = 60,
  parameter int SNOOZE_S = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hh,
  input  logic [5:0] cur_mm,
  input  logic [4:0] alm_hh,
  input  logic [5:0] alm_mm,
  input  logic       alm_en,
  input  logic       stop,
  input  logic       snooze,
  output logic       alarm,
  output logic       snoozing
);

`ifdef ALARM_SNOOZE_EN
  localparam int CNT_MAX = (RING_S > SNOOZE_S) ? RING_S : SNOOZE_S;
`else
  localparam int CNT_MAX = RING_S;
`endif
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RING_LAST = CW'(RING_S - 1);
`ifdef ALARM_SNOOZE_EN
  localparam logic [CW-1:0] SNOOZE_LAST = CW'(SNOOZE_S - 1);
`endif

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE    = 1'b0,
    RINGING = 1'b1
  } state_t;
`endif

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          match;
  logic          match_q;
  logic          trig;

  assign match = (cur_hh == alm_hh) && (cur_mm == alm_mm);
  assign trig  = match && !match_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Disarming overrides every other input, including stop and timeout.
  always_comb begin
    state_next = state;
    if (!alm_en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (trig) state_next = RINGING;
        end
        RINGING: begin
          if (stop) begin
            state_next = IDLE;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze) begin
            state_next = SNOOZE;
`endif
          end else if (tick_1hz && (cnt == RING_LAST)) begin
            state_next = IDLE;
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (stop) begin
            state_next = IDLE;
          end else if (tick_1hz && (cnt == SNOOZE_LAST)) begin
            state_next = RINGING;
          end
        end
`endif
        default: state_next = IDLE;
      endcase
    end
  end

  // Counter restarts on every state change so each phase gets its full duration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state_next != state) begin
      cnt <= '0;
    end else if ((state != IDLE) && tick_1hz) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign alarm = (state == RINGING);

`ifdef ALARM_SNOOZE_EN
  assign snoozing = (state == SNOOZE);
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
  assign snoozing      = 1'b0;
`endif

endmodule
